viterbi_ctrl: RTL and testbench
===============================

VITERBI_CTRL -- requirements
Module: viterbi_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16: received symbol pairs per frame; legal range 2..256.
REQ-002 SHALL have parameter AW, default 4: survivor-memory address width; AW = ceil(log2(FRAME_LEN)).
REQ-003 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have ports in_valid in 1, in_ready out 1, rx_pair in 2: received-symbol stream with valid/ready handshake.
REQ-006 SHALL have port bmc_rx_pair  out  2: registered symbol pair broadcast to all 8 branch-metric units.
REQ-007 SHALL have ports acs_en out 1 and acs_clr out 1: ACS update strobe; clear path metrics (acs_clr) on the first symbol of a frame.
REQ-008 SHALL have ports sm_wr_en out 1 and sm_addr out AW: survivor-memory write strobe and shared read/write address.
REQ-009 SHALL have ports tb_load out 1 and tb_en out 1: load the best end state into traceback; step traceback one position.
REQ-010 SHALL have port tb_bit  in  1: decoded bit from the traceback unit for the current sm_addr, valid combinationally.
REQ-011 SHALL have ports dec_bit out 1, dec_valid out 1, out_ready in 1, dec_last out 1: decoded-bit stream, emitted in reverse symbol order.
REQ-012 SHALL have ports busy out 1 and frame_done out 1: busy is high in any non-IDLE state; frame_done is a one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, ACS, FLUSH, TB.
REQ-014 in_ready SHALL be 1 in IDLE and ACS and 0 in FLUSH and TB; a symbol is accepted on in_valid & in_ready.
REQ-015 On acceptance of symbol k (k = 0..FRAME_LEN-1) at cycle t, at t+1 the block SHALL drive: bmc_rx_pair = rx_pair, acs_en = 1, sm_wr_en = 1, sm_addr = k, acs_clr = (k == 0).
REQ-016 acs_en, sm_wr_en and acs_clr SHALL be 0 in every cycle not following an acceptance; bmc_rx_pair SHALL hold its last value.
REQ-017 IDLE SHALL go to ACS on acceptance of k=0; in_valid low SHALL stall the frame indefinitely with no strobes.
REQ-018 Acceptance of k = FRAME_LEN-1 SHALL move the FSM to FLUSH; FLUSH SHALL last exactly one cycle, with the last write strobes and tb_load = 1 in that cycle.
REQ-019 TB SHALL start with sm_addr = FRAME_LEN-1; dec_valid = 1 and dec_bit = tb_bit throughout TB.
REQ-020 In TB, tb_en SHALL equal out_ready, and sm_addr SHALL decrement on each dec_valid & out_ready transfer.
REQ-021 out_ready low in TB SHALL hold sm_addr, dec_bit source and state unchanged.
REQ-022 dec_last SHALL be 1 only while sm_addr = 0 in TB; the transfer at sm_addr = 0 SHALL return the FSM to IDLE with sm_addr = 0, and frame_done = 1 in the next cycle.
REQ-023 The symbol counter SHALL never wrap within a frame; in_valid outside IDLE/ACS and out_ready outside TB SHALL be ignored.
REQ-024 A new frame MAY be accepted in the same cycle that frame_done is high.

Reset
REQ-025 While rst = 1 at a clock edge, the FSM SHALL go to IDLE and all registered outputs SHALL become 0 (bmc_rx_pair = 2'b00, sm_addr = 0).
REQ-026 in_ready SHALL be 0 during any cycle with rst high and 1 in the first cycle after release.
REQ-027 Reset mid-frame SHALL discard the partial frame; no frame_done SHALL be pulsed.

Configuration
REQ-028 Macro VITERBI_CTRL_ABORT_EN SHALL control the abort feature.
REQ-029 With VITERBI_CTRL_ABORT_EN defined, the block SHALL add ports abort in 1 and aborted out 1; abort high in a non-IDLE state SHALL behave as REQ-025/027 for the datapath outputs, and aborted SHALL pulse 1 in the next cycle; abort in IDLE SHALL be ignored; rst SHALL take priority over abort.
REQ-030 Without VITERBI_CTRL_ABORT_EN, neither port SHALL exist and behaviour SHALL be per REQ-013..027 only.

Verification (FRAME_LEN = 4)
REQ-031 Four back-to-back symbols 01,10,11,00 with out_ready = 1 SHALL produce:
- acs_en/sm_wr_en high on four cycles with sm_addr 0,1,2,3;
- acs_clr high only with addr 0;
- tb_load high for one cycle;
- four dec_valid beats at sm_addr 3,2,1,0, with dec_last on the 4th;
- frame_done high 1 cycle later.
REQ-032 Symbols with in_valid gaps of 2 cycles SHALL produce no extra strobes, and the sm_addr sequence SHALL remain 0..3.
REQ-033 out_ready toggled 1,0,0,1,... in TB SHALL hold sm_addr during the 0 cycles, tb_en SHALL follow out_ready, and exactly four transfers SHALL occur.
REQ-034 rst asserted after symbol 2 SHALL give all outputs 0 next cycle, in_ready = 1 after release, no frame_done; the next frame SHALL start at addr 0 with acs_clr = 1.
REQ-035 in_valid held high in FLUSH/TB SHALL result in no acceptance; the first symbol SHALL be accepted only after return to IDLE.
REQ-036 With VITERBI_CTRL_ABORT_EN defined, abort during TB at sm_addr 2 SHALL return the FSM to IDLE, pulse aborted once, and produce no frame_done.

Source files
------------

// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl: frame sequencer for a K=3 Viterbi decoder.
// Accepts FRAME_LEN received symbol pairs and drives the branch-metric/ACS
// strobes and survivor-memory writes. After a one-cycle flush it walks the
// survivor memory backwards and streams the decoded bits out in reverse
// symbol order.
// Optional feature: define VITERBI_CTRL_ABORT_EN to add the abort/aborted
// ports, which discard the frame in progress.
module viterbi_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int AW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    rx_pair,
    output logic [1:0]    bmc_rx_pair,
    output logic          acs_en,
    output logic          acs_clr,
    output logic          sm_wr_en,
    output logic [AW-1:0] sm_addr,
    output logic          tb_load,
    output logic          tb_en,
    input  logic          tb_bit,
    output logic          dec_bit,
    output logic          dec_valid,
    input  logic          out_ready,
    output logic          dec_last,
    output logic          busy,
    output logic          frame_done
`ifdef VITERBI_CTRL_ABORT_EN
    ,
    input  logic          abort,
    output logic          aborted
`endif
);

    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACS   = 2'd1,
        FLUSH = 2'd2,
        TB    = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [AW-1:0] addr_n;
    logic [1:0]    bmc_n;
    logic          acs_en_n, acs_clr_n, wr_n, done_n;
    logic          accept;
    logic          kill;

`ifdef VITERBI_CTRL_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    // Next-state and next-register values; handshake and traceback outputs.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        addr_n    = sm_addr;
        bmc_n     = bmc_rx_pair;
        acs_en_n  = 1'b0;
        acs_clr_n = 1'b0;
        wr_n      = 1'b0;
        done_n    = 1'b0;

        in_ready  = !rst && !kill && ((state == IDLE) || (state == ACS));
        accept    = in_valid && in_ready;
        tb_load   = (state == FLUSH);
        dec_valid = (state == TB);
        tb_en     = dec_valid && out_ready;
        dec_bit   = dec_valid && tb_bit;
        dec_last  = dec_valid && (sm_addr == '0);
        busy      = (state != IDLE);

        case (state)
            IDLE, ACS: begin
                if (accept) begin
                    bmc_n     = rx_pair;
                    acs_en_n  = 1'b1;
                    wr_n      = 1'b1;
                    acs_clr_n = (cnt == '0);
                    addr_n    = cnt;
                    if (cnt == LAST) begin
                        // Counter parks at zero so it never wraps mid-frame.
                        cnt_n   = '0;
                        state_n = FLUSH;
                    end else begin
                        cnt_n   = cnt + 1'b1;
                        state_n = ACS;
                    end
                end
            end
            FLUSH: begin
                // sm_addr already holds FRAME_LEN-1 from the last write.
                state_n = TB;
            end
            TB: begin
                if (out_ready) begin
                    if (sm_addr == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        addr_n = sm_addr - 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state register; reset or abort drops back to IDLE.
    always_ff @(posedge clk) begin
        if (rst || kill) state <= IDLE;
        else             state <= state_n;
    end

    // Registered strobes, address, symbol counter and broadcast pair.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            cnt         <= '0;
            sm_addr     <= '0;
            bmc_rx_pair <= 2'b00;
            acs_en      <= 1'b0;
            acs_clr     <= 1'b0;
            sm_wr_en    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            sm_addr     <= addr_n;
            bmc_rx_pair <= bmc_n;
            acs_en      <= acs_en_n;
            acs_clr     <= acs_clr_n;
            sm_wr_en    <= wr_n;
            frame_done  <= done_n;
        end
    end

`ifdef VITERBI_CTRL_ABORT_EN
    // One-cycle abort acknowledge; reset has priority and suppresses it.
    always_ff @(posedge clk) begin
        if (rst) aborted <= 1'b0;
        else     aborted <= kill;
    end
`endif

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb_viterbi_ctrl: directed and random stimulus for viterbi_ctrl with
// FRAME_LEN = 4, checked cycle by cycle against a frame-level model that
// tracks how many symbols were received and where traceback stands.
module tb_viterbi_ctrl;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_ready, tb_bit;
    logic [1:0] rx_pair, bmc_rx_pair;
    logic       acs_en, acs_clr, sm_wr_en, tb_load, tb_en;
    logic [1:0] sm_addr;
    logic       dec_bit, dec_valid, dec_last, busy, frame_done;
    logic       abort, aborted;

    always #5 clk = ~clk;

    viterbi_ctrl #(.FRAME_LEN(N), .AW(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rx_pair(rx_pair), .bmc_rx_pair(bmc_rx_pair), .acs_en(acs_en),
        .acs_clr(acs_clr), .sm_wr_en(sm_wr_en), .sm_addr(sm_addr),
        .tb_load(tb_load), .tb_en(tb_en), .tb_bit(tb_bit), .dec_bit(dec_bit),
        .dec_valid(dec_valid), .out_ready(out_ready), .dec_last(dec_last),
        .busy(busy), .frame_done(frame_done)
`ifdef VITERBI_CTRL_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

`ifndef VITERBI_CTRL_ABORT_EN
    assign aborted = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Frame-level model: symbols received, flush pending, traceback position.
    int   m_n     = 0;
    bit   m_flush = 1'b0;
    int   m_tb    = -1;
    int   m_addr  = 0;
    logic [1:0] m_bmc = 2'b00;
    bit   m_acs = 1'b0, m_clr = 1'b0, m_done = 1'b0, m_ab = 1'b0;
    int   acc_cnt = 0, xfer_cnt = 0, done_cnt = 0, ab_cnt = 0;

    logic [1:0] syms [4];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        acc_cnt = 0; xfer_cnt = 0; done_cnt = 0; ab_cnt = 0;
    endtask

    task automatic cyc(input bit r, input bit iv, input logic [1:0] rx,
                       input bit ordy, input bit ab);
        bit nonidle, exp_rdy, acc, kill;
        rst = r; in_valid = iv; rx_pair = rx; out_ready = ordy; abort = ab;
        tb_bit = 1'($urandom_range(0, 1));
        #1;
        nonidle = (m_n > 0) || m_flush || (m_tb >= 0);
`ifdef VITERBI_CTRL_ABORT_EN
        kill = ab && nonidle && !r;
`else
        kill = 1'b0;
`endif
        exp_rdy = !r && !kill && !m_flush && (m_tb < 0);
        chk("in_ready",  8'(in_ready),  8'(exp_rdy));
        chk("busy",      8'(busy),      8'(nonidle));
        chk("tb_load",   8'(tb_load),   8'(m_flush));
        chk("dec_valid", 8'(dec_valid), 8'(m_tb >= 0));
        chk("tb_en",     8'(tb_en),     8'((m_tb >= 0) && ordy));
        chk("dec_last",  8'(dec_last),  8'(m_tb == 0));
        if (m_tb >= 0) chk("dec_bit", 8'(dec_bit), 8'(tb_bit));
        acc = iv && exp_rdy;

        @(posedge clk);
        m_acs = 1'b0; m_clr = 1'b0; m_done = 1'b0; m_ab = 1'b0;
        if (r || kill) begin
            m_n = 0; m_flush = 1'b0; m_tb = -1; m_bmc = 2'b00; m_addr = 0;
            m_ab = kill;
            if (kill) ab_cnt++;
        end else begin
            if (m_flush) begin
                m_flush = 1'b0;
                m_tb = N - 1;
            end else if (m_tb >= 0 && ordy) begin
                xfer_cnt++;
                if (m_tb == 0) begin
                    m_tb = -1; m_addr = 0; m_done = 1'b1; done_cnt++;
                end else begin
                    m_tb--; m_addr = m_tb;
                end
            end
            if (acc) begin
                m_acs = 1'b1; m_clr = (m_n == 0); m_bmc = rx; m_addr = m_n;
                m_n++; acc_cnt++;
                if (m_n == N) begin m_n = 0; m_flush = 1'b1; end
            end
        end

        #1;
        chk("bmc_rx_pair", 8'(bmc_rx_pair), 8'(m_bmc));
        chk("acs_en",      8'(acs_en),      8'(m_acs));
        chk("sm_wr_en",    8'(sm_wr_en),    8'(m_acs));
        chk("acs_clr",     8'(acs_clr),     8'(m_clr));
        chk("sm_addr",     8'(sm_addr),     8'(m_addr));
        chk("frame_done",  8'(frame_done),  8'(m_done));
        chk("aborted",     8'(aborted),     8'(m_ab));
    endtask

    initial begin
        syms[0] = 2'b01; syms[1] = 2'b10; syms[2] = 2'b11; syms[3] = 2'b00;
        rst = 1'b1; in_valid = 1'b0; rx_pair = 2'b00; out_ready = 1'b0;
        abort = 1'b0; tb_bit = 1'b0;

        // Reset: in_ready low while held, all registered outputs zero.
        cyc(1, 1, 2'b11, 1, 0);
        cyc(1, 0, 2'b00, 0, 0);

        // Back-to-back frame, out_ready always high.
        clr_counts();
        for (int i = 0; i < 4; i++) cyc(0, 1, syms[i], 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 2'b00, 1, 0);
        chk("f1_accepts", 8'(acc_cnt), 8'd4);
        chk("f1_xfers",   8'(xfer_cnt), 8'd4);
        chk("f1_done",    8'(done_cnt), 8'd1);

        // Two-cycle gaps between symbols.
        clr_counts();
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, syms[3 - i], 1, 0);
            cyc(0, 0, 2'b01, 1, 0);
            cyc(0, 0, 2'b10, 1, 0);
        end
        for (int i = 0; i < 5; i++) cyc(0, 0, 2'b00, 1, 0);
        chk("gap_accepts", 8'(acc_cnt), 8'd4);
        chk("gap_done",    8'(done_cnt), 8'd1);

        // out_ready toggled 1,0,0,1 during traceback.
        clr_counts();
        for (int i = 0; i < 4; i++) cyc(0, 1, syms[i], 1, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 2'b00, (i % 4 == 0) || (i % 4 == 3), 0);
        chk("tog_xfers", 8'(xfer_cnt), 8'd4);
        chk("tog_done",  8'(done_cnt), 8'd1);

        // Reset after symbol 2, then a fresh frame from address 0.
        clr_counts();
        for (int i = 0; i < 3; i++) cyc(0, 1, syms[i], 1, 0);
        cyc(1, 1, 2'b11, 1, 0);
        cyc(0, 0, 2'b00, 1, 0);
        chk("rst_nodone", 8'(done_cnt), 8'd0);
        for (int i = 0; i < 4; i++) cyc(0, 1, syms[i], 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 2'b00, 1, 0);
        chk("rst_done", 8'(done_cnt), 8'd1);

        // in_valid held high through FLUSH/TB: next frame starts in IDLE.
        clr_counts();
        for (int i = 0; i < 14; i++) cyc(0, 1, 2'($urandom_range(0, 3)), 1, 0);
        chk("hold_accepts", 8'(acc_cnt), 8'd8);
        for (int i = 0; i < 6; i++) cyc(0, 0, 2'b00, 1, 0);

`ifdef VITERBI_CTRL_ABORT_EN
        // Abort during traceback at sm_addr 2, then abort in IDLE.
        clr_counts();
        for (int i = 0; i < 4; i++) cyc(0, 1, syms[i], 1, 0);
        cyc(0, 0, 2'b00, 1, 0);
        cyc(0, 0, 2'b00, 1, 0);
        chk("ab_addr", 8'(sm_addr), 8'd2);
        cyc(0, 0, 2'b00, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 2'b00, 1, i == 2);
        chk("ab_count", 8'(ab_cnt), 8'd1);
        chk("ab_nodone", 8'(done_cnt), 8'd0);
`endif

        // Random traffic with occasional reset and abort.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                $urandom_range(0, 31) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
